// File: rtl/sa_ctrl_pkg.sv
// Shared definitions for the systolic-array tile controller: state encoding,
// drain-length helper and host passthrough constants.
package sa_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_WB    = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    localparam logic HOST_SRAM_EN = 1'b1;
    localparam logic HOST_WR_WE   = 1'b1;
    localparam logic HOST_RD_WE   = 1'b0;

    // Cycles until the last product has left the array after the final read issue
    function automatic int unsigned drain_len(input int unsigned rd_lat,
                                              input int unsigned num_row,
                                              input int unsigned num_col);
        return rd_lat + num_row + num_col - 1;
    endfunction

endpackage

// File: rtl/sa_tile_controller_if.sv
// Host/SRAM/datapath signal bundle of the tile controller; master is the host side.
interface sa_tile_controller_if #(
    parameter int unsigned NUM_ROW              = 8,
    parameter int unsigned NUM_COL              = 8,
    parameter int unsigned LOG2_SRAM_BANK_DEPTH = 10,
    parameter int unsigned LOG2_K               = 10,
    parameter int unsigned LOG2_TILES           = 8
);
    logic                            i_start;
    logic [LOG2_K-1:0]               i_k_len;
    logic [LOG2_TILES-1:0]           i_num_tiles;
    logic [LOG2_SRAM_BANK_DEPTH-1:0] i_top_base;
    logic [LOG2_SRAM_BANK_DEPTH-1:0] i_left_base;
    logic [LOG2_SRAM_BANK_DEPTH-1:0] i_down_base;
    logic                            i_host_top_wr_en;
    logic                            i_host_left_wr_en;
    logic                            i_host_down_rd_en;
    logic [LOG2_SRAM_BANK_DEPTH-1:0] i_host_addr;

    logic                            o_top_en;
    logic                            o_top_we;
    logic [LOG2_SRAM_BANK_DEPTH-1:0] o_top_addr;
    logic                            o_left_en;
    logic                            o_left_we;
    logic [LOG2_SRAM_BANK_DEPTH-1:0] o_left_addr;
    logic [NUM_COL-1:0]              o_down_en;
    logic                            o_down_we;
    logic [LOG2_SRAM_BANK_DEPTH-1:0] o_down_addr;
    logic [NUM_COL-1:0]              o_valid_top;
    logic [NUM_ROW-1:0]              o_valid_left;
    logic                            o_sa_acc_clr;
    logic                            o_sa_shift_out;
    logic                            o_busy;
    logic                            o_done;
    logic                            o_err;

    modport master (
        output i_start, i_k_len, i_num_tiles, i_top_base, i_left_base, i_down_base,
               i_host_top_wr_en, i_host_left_wr_en, i_host_down_rd_en, i_host_addr,
        input  o_top_en, o_top_we, o_top_addr, o_left_en, o_left_we, o_left_addr,
               o_down_en, o_down_we, o_down_addr, o_valid_top, o_valid_left,
               o_sa_acc_clr, o_sa_shift_out, o_busy, o_done, o_err
    );

    modport slave (
        input  i_start, i_k_len, i_num_tiles, i_top_base, i_left_base, i_down_base,
               i_host_top_wr_en, i_host_left_wr_en, i_host_down_rd_en, i_host_addr,
        output o_top_en, o_top_we, o_top_addr, o_left_en, o_left_we, o_left_addr,
               o_down_en, o_down_we, o_down_addr, o_valid_top, o_valid_left,
               o_sa_acc_clr, o_sa_shift_out, o_busy, o_done, o_err
    );

endinterface

// File: rtl/sa_valid_skew.sv
// Per-lane valid delay line: lane l sees issue_i delayed by BASE_LAT (+ l when skewed).
module sa_valid_skew #(
    parameter int unsigned LANES    = 8,
    parameter int unsigned BASE_LAT = 1,
    parameter int unsigned SKEW_EN  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_i,
    output logic [LANES-1:0] valid_o
);

    localparam int unsigned DEPTH = BASE_LAT + ((SKEW_EN != 0) ? (LANES - 1) : 0);

    logic [DEPTH-1:0] pipe_q;

    if (DEPTH == 1) begin : g_one
        always_ff @(posedge clk) begin
            if (rst) pipe_q <= '0;
            else     pipe_q <= issue_i;
        end
    end else begin : g_many
        always_ff @(posedge clk) begin
            if (rst) pipe_q <= '0;
            else     pipe_q <= {pipe_q[DEPTH-2:0], issue_i};
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign valid_o[l] = pipe_q[BASE_LAT - 1 + ((SKEW_EN != 0) ? l : 0)];
    end

endmodule

// File: rtl/sa_tile_controller.sv
// Tiled GEMM sequencer: clear, feed, drain and writeback per tile from one start pulse,
// with host SRAM passthrough while idle.
module sa_tile_controller
    import sa_ctrl_pkg::*;
#(
    parameter int unsigned NUM_ROW              = 8,
    parameter int unsigned NUM_COL              = 8,
    parameter int unsigned LOG2_SRAM_BANK_DEPTH = 10,
    parameter int unsigned LOG2_K               = 10,
    parameter int unsigned LOG2_TILES           = 8,
    parameter int unsigned SRAM_RD_LAT          = 1,
    parameter int unsigned SKEW_EN              = 1
) (
    input logic                 clk,
    input logic                 rst,
    sa_tile_controller_if.slave bus
);

    localparam int unsigned AW        = LOG2_SRAM_BANK_DEPTH;
    localparam int unsigned DRAIN_LEN = drain_len(SRAM_RD_LAT, NUM_ROW, NUM_COL);
    localparam int unsigned PH_MAX    = (DRAIN_LEN > NUM_ROW) ? DRAIN_LEN : NUM_ROW;
    localparam int unsigned PH_W      = $clog2(PH_MAX + 1);

    state_e                state_q, state_d;
    logic [LOG2_K-1:0]     k_q, k_d;
    logic [LOG2_K-1:0]     k_len_q, k_len_d;
    logic [LOG2_TILES-1:0] num_tiles_q, num_tiles_d;
    logic [LOG2_TILES-1:0] tile_q, tile_d;
    logic [PH_W-1:0]       ph_q, ph_d;
    logic [AW-1:0]         top_ptr_q, top_ptr_d;
    logic [AW-1:0]         left_ptr_q, left_ptr_d;
    logic [AW-1:0]         down_ptr_q, down_ptr_d;
    logic                  err_q, err_d;

    logic               top_en, top_we, left_en, left_we, down_we;
    logic [AW-1:0]      top_addr, left_addr, down_addr;
    logic [NUM_COL-1:0] down_en;
    logic               acc_clr, shift_out, busy, done, err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            k_len_q     <= '0;
            num_tiles_q <= '0;
            tile_q      <= '0;
            ph_q        <= '0;
            top_ptr_q   <= '0;
            left_ptr_q  <= '0;
            down_ptr_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            k_len_q     <= k_len_d;
            num_tiles_q <= num_tiles_d;
            tile_q      <= tile_d;
            ph_q        <= ph_d;
            top_ptr_q   <= top_ptr_d;
            left_ptr_q  <= left_ptr_d;
            down_ptr_q  <= down_ptr_d;
            err_q       <= err_d;
        end
    end

    // Sequencing and Moore-decoded outputs; ph_q counts both drain cycles and writeback rows
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        k_len_d     = k_len_q;
        num_tiles_d = num_tiles_q;
        tile_d      = tile_q;
        ph_d        = ph_q;
        top_ptr_d   = top_ptr_q;
        left_ptr_d  = left_ptr_q;
        down_ptr_d  = down_ptr_q;
        err_d       = err_q;

        top_en    = 1'b0;
        top_we    = 1'b0;
        top_addr  = '0;
        left_en   = 1'b0;
        left_we   = 1'b0;
        left_addr = '0;
        down_en   = '0;
        down_we   = 1'b0;
        down_addr = '0;
        acc_clr   = 1'b0;
        shift_out = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        err       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (bus.i_host_top_wr_en) begin
                    top_en   = HOST_SRAM_EN;
                    top_we   = HOST_WR_WE;
                    top_addr = bus.i_host_addr;
                end
                if (bus.i_host_left_wr_en) begin
                    left_en   = HOST_SRAM_EN;
                    left_we   = HOST_WR_WE;
                    left_addr = bus.i_host_addr;
                end
                if (bus.i_host_down_rd_en) begin
                    down_en   = '1;
                    down_we   = HOST_RD_WE;
                    down_addr = bus.i_host_addr;
                end
                if (bus.i_start) begin
                    k_len_d     = bus.i_k_len;
                    num_tiles_d = bus.i_num_tiles;
                    top_ptr_d   = bus.i_top_base;
                    left_ptr_d  = bus.i_left_base;
                    down_ptr_d  = bus.i_down_base;
                    tile_d      = '0;
                    ph_d        = '0;
                    k_d         = '0;
                    if ((bus.i_k_len == '0) || (bus.i_num_tiles == '0)) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ST_CLEAR;
                    end
                end
            end
            ST_CLEAR: begin
                acc_clr = 1'b1;
                k_d     = '0;
                state_d = ST_FEED;
            end
            ST_FEED: begin
                top_en    = 1'b1;
                top_addr  = top_ptr_q + AW'(k_q);
                left_en   = 1'b1;
                left_addr = left_ptr_q + AW'(k_q);
                if (k_q == k_len_q - LOG2_K'(1)) begin
                    ph_d    = '0;
                    state_d = ST_DRAIN;
                end else begin
                    k_d = k_q + LOG2_K'(1);
                end
            end
            ST_DRAIN: begin
                if (ph_q == PH_W'(DRAIN_LEN - 1)) begin
                    ph_d    = '0;
                    state_d = ST_WB;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            ST_WB: begin
                shift_out = 1'b1;
                down_en   = '1;
                down_we   = 1'b1;
                down_addr = down_ptr_q + AW'(ph_q);
                if (ph_q == PH_W'(NUM_ROW - 1)) begin
                    ph_d = '0;
                    if (tile_q == num_tiles_q - LOG2_TILES'(1)) begin
                        state_d = ST_DONE;
                    end else begin
                        tile_d     = tile_q + LOG2_TILES'(1);
                        top_ptr_d  = top_ptr_q + AW'(k_len_q);
                        left_ptr_d = left_ptr_q + AW'(k_len_q);
                        down_ptr_d = down_ptr_q + AW'(NUM_ROW);
                        state_d    = ST_CLEAR;
                    end
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            ST_DONE: begin
                busy    = 1'b0;
                done    = 1'b1;
                err     = err_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    sa_valid_skew #(
        .LANES    (NUM_COL),
        .BASE_LAT (SRAM_RD_LAT),
        .SKEW_EN  (SKEW_EN)
    ) u_skew_top (
        .clk     (clk),
        .rst     (rst),
        .issue_i (state_q == ST_FEED),
        .valid_o (bus.o_valid_top)
    );

    sa_valid_skew #(
        .LANES    (NUM_ROW),
        .BASE_LAT (SRAM_RD_LAT),
        .SKEW_EN  (SKEW_EN)
    ) u_skew_left (
        .clk     (clk),
        .rst     (rst),
        .issue_i (state_q == ST_FEED),
        .valid_o (bus.o_valid_left)
    );

    assign bus.o_top_en       = top_en;
    assign bus.o_top_we       = top_we;
    assign bus.o_top_addr     = top_addr;
    assign bus.o_left_en      = left_en;
    assign bus.o_left_we      = left_we;
    assign bus.o_left_addr    = left_addr;
    assign bus.o_down_en      = down_en;
    assign bus.o_down_we      = down_we;
    assign bus.o_down_addr    = down_addr;
    assign bus.o_sa_acc_clr   = acc_clr;
    assign bus.o_sa_shift_out = shift_out;
    assign bus.o_busy         = busy;
    assign bus.o_done         = done;
    assign bus.o_err          = err;

endmodule

// File: tb/tb_sa_tile_controller.sv
// Directed bench for sa_tile_controller: 4x4 array, skewed (A) and aligned (B) valid instances.
module tb_sa_tile_controller;

    localparam int unsigned NR = 4;
    localparam int unsigned NC = 4;
    localparam int unsigned AW = 10;
    localparam int unsigned KW = 10;
    localparam int unsigned TW = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sa_tile_controller_if #(.NUM_ROW(NR), .NUM_COL(NC), .LOG2_SRAM_BANK_DEPTH(AW),
                            .LOG2_K(KW), .LOG2_TILES(TW)) bus_a ();
    sa_tile_controller_if #(.NUM_ROW(NR), .NUM_COL(NC), .LOG2_SRAM_BANK_DEPTH(AW),
                            .LOG2_K(KW), .LOG2_TILES(TW)) bus_b ();

    sa_tile_controller #(.NUM_ROW(NR), .NUM_COL(NC), .LOG2_SRAM_BANK_DEPTH(AW), .LOG2_K(KW),
                         .LOG2_TILES(TW), .SRAM_RD_LAT(1), .SKEW_EN(1))
        u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));

    sa_tile_controller #(.NUM_ROW(NR), .NUM_COL(NC), .LOG2_SRAM_BANK_DEPTH(AW), .LOG2_K(KW),
                         .LOG2_TILES(TW), .SRAM_RD_LAT(1), .SKEW_EN(0))
        u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    typedef struct {
        int unsigned   off;
        logic          clr;
        logic          ten;
        logic [AW-1:0] taddr;
        logic [AW-1:0] laddr;
        logic [NC-1:0] vld;
        logic          dwe;
        logic [AW-1:0] daddr;
        logic          done;
        logic          busy;
    } vec_t;

    vec_t tbl [17];

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] tq [$];
    logic [AW-1:0] dq [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_a(input logic [KW-1:0] k, input logic [TW-1:0] tiles,
                           input logic [AW-1:0] tb, input logic [AW-1:0] lb,
                           input logic [AW-1:0] db);
        bus_a.i_k_len       = k;
        bus_a.i_num_tiles   = tiles;
        bus_a.i_top_base    = tb;
        bus_a.i_left_base   = lb;
        bus_a.i_down_base   = db;
        bus_a.i_start       = 1'b1;
    endtask

    task automatic check_quiet_a(input string tag);
        chk({tag, " busy"},  32'(bus_a.o_busy), 32'd0);
        chk({tag, " clr"},   32'(bus_a.o_sa_acc_clr), 32'd0);
        chk({tag, " shift"}, 32'(bus_a.o_sa_shift_out), 32'd0);
        chk({tag, " ten"},   32'(bus_a.o_top_en), 32'd0);
        chk({tag, " len"},   32'(bus_a.o_left_en), 32'd0);
        chk({tag, " den"},   32'(bus_a.o_down_en), 32'd0);
        chk({tag, " vtop"},  32'(bus_a.o_valid_top), 32'd0);
        chk({tag, " vleft"}, 32'(bus_a.o_valid_left), 32'd0);
        chk({tag, " done"},  32'(bus_a.o_done), 32'd0);
        chk({tag, " err"},   32'(bus_a.o_err), 32'd0);
    endtask

    // One K=3 single-tile run checked cycle by cycle; at poke_off a start and host requests are injected
    task automatic run_table(input int unsigned poke_off, input string tag);
        start_a(KW'(3), TW'(1), 10'h010, 10'h020, 10'h100);
        for (int i = 0; i < 17; i++) begin
            vec_t v;
            string p;
            v = tbl[i];
            tick();
            bus_a.i_start           = (v.off == poke_off);
            bus_a.i_host_down_rd_en = (v.off == poke_off);
            bus_a.i_host_top_wr_en  = (v.off == poke_off);
            bus_a.i_k_len           = (v.off == poke_off) ? KW'(7) : KW'(3);
            #1;
            p = $sformatf("%s[t+%0d]", tag, v.off);
            chk({p, " clr"},   32'(bus_a.o_sa_acc_clr), 32'(v.clr));
            chk({p, " ten"},   32'(bus_a.o_top_en), 32'(v.ten));
            chk({p, " len"},   32'(bus_a.o_left_en), 32'(v.ten));
            chk({p, " twe"},   32'(bus_a.o_top_we), 32'd0);
            chk({p, " vtop"},  32'(bus_a.o_valid_top), 32'(v.vld));
            chk({p, " vleft"}, 32'(bus_a.o_valid_left), 32'(v.vld));
            chk({p, " dwe"},   32'(bus_a.o_down_we), 32'(v.dwe));
            chk({p, " den"},   32'(bus_a.o_down_en), v.dwe ? 32'hF : 32'h0);
            chk({p, " shift"}, 32'(bus_a.o_sa_shift_out), 32'(v.dwe));
            chk({p, " done"},  32'(bus_a.o_done), 32'(v.done));
            chk({p, " err"},   32'(bus_a.o_err), 32'd0);
            chk({p, " busy"},  32'(bus_a.o_busy), 32'(v.busy));
            if (v.ten) begin
                chk({p, " taddr"}, 32'(bus_a.o_top_addr), 32'(v.taddr));
                chk({p, " laddr"}, 32'(bus_a.o_left_addr), 32'(v.laddr));
            end
            if (v.dwe) chk({p, " daddr"}, 32'(bus_a.o_down_addr), 32'(v.daddr));
        end
        bus_a.i_start = 1'b0;
        bus_a.i_host_down_rd_en = 1'b0;
        bus_a.i_host_top_wr_en  = 1'b0;
        tick();
        check_quiet_a({tag, " after"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int dones;
        int en_seen;
        int cnt;
        logic [AW-1:0] last_addr;

        //           off clr  ten   taddr    laddr    vld   dwe   daddr    done  busy
        tbl[0]  = '{ 1, 1'b1, 1'b0, 10'h000, 10'h000, 4'h0, 1'b0, 10'h000, 1'b0, 1'b1};
        tbl[1]  = '{ 2, 1'b0, 1'b1, 10'h010, 10'h020, 4'h0, 1'b0, 10'h000, 1'b0, 1'b1};
        tbl[2]  = '{ 3, 1'b0, 1'b1, 10'h011, 10'h021, 4'h1, 1'b0, 10'h000, 1'b0, 1'b1};
        tbl[3]  = '{ 4, 1'b0, 1'b1, 10'h012, 10'h022, 4'h3, 1'b0, 10'h000, 1'b0, 1'b1};
        tbl[4]  = '{ 5, 1'b0, 1'b0, 10'h000, 10'h000, 4'h7, 1'b0, 10'h000, 1'b0, 1'b1};
        tbl[5]  = '{ 6, 1'b0, 1'b0, 10'h000, 10'h000, 4'hE, 1'b0, 10'h000, 1'b0, 1'b1};
        tbl[6]  = '{ 7, 1'b0, 1'b0, 10'h000, 10'h000, 4'hC, 1'b0, 10'h000, 1'b0, 1'b1};
        tbl[7]  = '{ 8, 1'b0, 1'b0, 10'h000, 10'h000, 4'h8, 1'b0, 10'h000, 1'b0, 1'b1};
        tbl[8]  = '{ 9, 1'b0, 1'b0, 10'h000, 10'h000, 4'h0, 1'b0, 10'h000, 1'b0, 1'b1};
        tbl[9]  = '{10, 1'b0, 1'b0, 10'h000, 10'h000, 4'h0, 1'b0, 10'h000, 1'b0, 1'b1};
        tbl[10] = '{11, 1'b0, 1'b0, 10'h000, 10'h000, 4'h0, 1'b0, 10'h000, 1'b0, 1'b1};
        tbl[11] = '{12, 1'b0, 1'b0, 10'h000, 10'h000, 4'h0, 1'b0, 10'h000, 1'b0, 1'b1};
        tbl[12] = '{13, 1'b0, 1'b0, 10'h000, 10'h000, 4'h0, 1'b1, 10'h100, 1'b0, 1'b1};
        tbl[13] = '{14, 1'b0, 1'b0, 10'h000, 10'h000, 4'h0, 1'b1, 10'h101, 1'b0, 1'b1};
        tbl[14] = '{15, 1'b0, 1'b0, 10'h000, 10'h000, 4'h0, 1'b1, 10'h102, 1'b0, 1'b1};
        tbl[15] = '{16, 1'b0, 1'b0, 10'h000, 10'h000, 4'h0, 1'b1, 10'h103, 1'b0, 1'b1};
        tbl[16] = '{17, 1'b0, 1'b0, 10'h000, 10'h000, 4'h0, 1'b0, 10'h000, 1'b1, 1'b0};

        rst = 1'b1;
        bus_a.i_start = 1'b0; bus_a.i_k_len = '0; bus_a.i_num_tiles = '0;
        bus_a.i_top_base = '0; bus_a.i_left_base = '0; bus_a.i_down_base = '0;
        bus_a.i_host_top_wr_en = 1'b0; bus_a.i_host_left_wr_en = 1'b0;
        bus_a.i_host_down_rd_en = 1'b0; bus_a.i_host_addr = '0;
        bus_b.i_start = 1'b0; bus_b.i_k_len = '0; bus_b.i_num_tiles = '0;
        bus_b.i_top_base = '0; bus_b.i_left_base = '0; bus_b.i_down_base = '0;
        bus_b.i_host_top_wr_en = 1'b0; bus_b.i_host_left_wr_en = 1'b0;
        bus_b.i_host_down_rd_en = 1'b0; bus_b.i_host_addr = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_quiet_a("reset");

        // Basic single tile
        run_table(0, "basic");

        // Three tiles with top bank wrapping past 0x3FF
        tq.delete();
        dq.delete();
        dones = 0;
        start_a(KW'(3), TW'(3), 10'h3FE, 10'h020, 10'h100);
        for (int i = 0; i < 70; i++) begin
            tick();
            bus_a.i_start = 1'b0;
            if (bus_a.o_top_en) tq.push_back(bus_a.o_top_addr);
            if (bus_a.o_down_we) dq.push_back(bus_a.o_down_addr);
            if (bus_a.o_done) begin
                dones++;
                chk("wrap err", 32'(bus_a.o_err), 32'd0);
            end
        end
        chk("wrap done pulses", 32'(dones), 32'd1);
        chk("wrap top reads", 32'(tq.size()), 32'd9);
        chk("wrap down writes", 32'(dq.size()), 32'd12);
        for (int j = 0; j < 9 && j < tq.size(); j++)
            chk($sformatf("wrap taddr%0d", j), 32'(tq[j]), 32'((10'h3FE + 10'(j)) & 10'h3FF));
        for (int j = 0; j < 12 && j < dq.size(); j++)
            chk($sformatf("wrap daddr%0d", j), 32'(dq[j]), 32'(10'h100 + 10'(j)));

        // Illegal configurations: K=0, then tiles=0
        for (int c = 0; c < 2; c++) begin
            dones = 0;
            en_seen = 0;
            start_a((c == 0) ? KW'(0) : KW'(3), (c == 0) ? TW'(1) : TW'(0),
                    10'h010, 10'h020, 10'h100);
            for (int i = 1; i <= 4; i++) begin
                tick();
                bus_a.i_start = 1'b0;
                if (bus_a.o_top_en || bus_a.o_left_en || (bus_a.o_down_en != '0)) en_seen++;
                if (bus_a.o_done) begin
                    dones++;
                    chk($sformatf("illegal%0d err", c), 32'(bus_a.o_err), 32'd1);
                    chk($sformatf("illegal%0d done time", c), 32'(i <= 2), 32'd1);
                end
            end
            chk($sformatf("illegal%0d done pulses", c), 32'(dones), 32'd1);
            chk($sformatf("illegal%0d sram enables", c), 32'(en_seen), 32'd0);
        end

        // Aligned valids on instance B
        bus_b.i_k_len = KW'(3); bus_b.i_num_tiles = TW'(1);
        bus_b.i_top_base = 10'h010; bus_b.i_left_base = 10'h020; bus_b.i_down_base = 10'h100;
        bus_b.i_start = 1'b1;
        for (int off = 1; off <= 7; off++) begin
            tick();
            bus_b.i_start = 1'b0;
            chk($sformatf("noskew vtop t+%0d", off), 32'(bus_b.o_valid_top),
                (off >= 3 && off <= 5) ? 32'hF : 32'h0);
            chk($sformatf("noskew vleft t+%0d", off), 32'(bus_b.o_valid_left),
                (off >= 3 && off <= 5) ? 32'hF : 32'h0);
        end
        dones = 0;
        for (int i = 0; i < 20 && dones == 0; i++) begin
            tick();
            if (bus_b.o_done) dones++;
        end
        chk("noskew done seen", 32'(dones), 32'd1);

        // Reset in the middle of DRAIN, then a clean rerun
        start_a(KW'(3), TW'(1), 10'h010, 10'h020, 10'h100);
        for (int off = 1; off <= 7; off++) begin
            tick();
            bus_a.i_start = 1'b0;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_quiet_a("drain reset");
        run_table(0, "rerun");

        // Start and host requests during FEED must be ignored
        run_table(3, "poke");

        // Host passthrough in IDLE
        bus_a.i_host_top_wr_en = 1'b1;
        bus_a.i_host_addr = 10'h005;
        #1;
        chk("host top en",   32'(bus_a.o_top_en), 32'd1);
        chk("host top we",   32'(bus_a.o_top_we), 32'd1);
        chk("host top addr", 32'(bus_a.o_top_addr), 32'h005);
        bus_a.i_host_top_wr_en = 1'b0;
        bus_a.i_host_left_wr_en = 1'b1;
        bus_a.i_host_addr = 10'h02A;
        #1;
        chk("host left en",   32'(bus_a.o_left_en), 32'd1);
        chk("host left we",   32'(bus_a.o_left_we), 32'd1);
        chk("host left addr", 32'(bus_a.o_left_addr), 32'h02A);
        chk("host left top idle", 32'(bus_a.o_top_en), 32'd0);
        bus_a.i_host_left_wr_en = 1'b0;
        bus_a.i_host_down_rd_en = 1'b1;
        bus_a.i_host_addr = 10'h333;
        #1;
        chk("host down en",   32'(bus_a.o_down_en), 32'hF);
        chk("host down we",   32'(bus_a.o_down_we), 32'd0);
        chk("host down addr", 32'(bus_a.o_down_addr), 32'h333);
        bus_a.i_host_down_rd_en = 1'b0;
        tick();

        // Maximum reduction length runs all 1023 reads
        cnt = 0;
        dones = 0;
        last_addr = '0;
        start_a(KW'(10'h3FF), TW'(1), 10'h000, 10'h000, 10'h000);
        for (int i = 0; i < 1100 && dones == 0; i++) begin
            tick();
            bus_a.i_start = 1'b0;
            if (bus_a.o_top_en) begin
                cnt++;
                last_addr = bus_a.o_top_addr;
            end
            if (bus_a.o_done) dones++;
        end
        chk("kmax reads", 32'(cnt), 32'd1023);
        chk("kmax last addr", 32'(last_addr), 32'h3FE);
        chk("kmax done", 32'(dones), 32'd1);
        tick();

        // Start coinciding with reset is dropped
        start_a(KW'(3), TW'(1), 10'h010, 10'h020, 10'h100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus_a.i_start = 1'b0;
        tick();
        chk("start in reset busy", 32'(bus_a.o_busy), 32'd0);
        chk("start in reset clr",  32'(bus_a.o_sa_acc_clr), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
